// File: rtl/uart_rx_fifo_if.sv
// Byte stream and consumer handshake between the UART receiver, the RX FIFO
// and the command logic that drains it.
interface uart_rx_fifo_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              rx_done;
  logic [7:0]        rx_data;
  logic              rd_en;
  logic              clear_ovf;
  logic [7:0]        dout;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overflow;

  // Producer/consumer side: drives strobes, observes data and status
  modport master (
    output rx_done, rx_data, rd_en, clear_ovf,
    input  dout, empty, full, count, overflow
  );

  // FIFO side
  modport slave (
    input  rx_done, rx_data, rd_en, clear_ovf,
    output dout, empty, full, count, overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO behind the UART receiver. Captures one byte per rising
// edge of rx_done into a circular buffer, tracks fill level and a sticky
// overflow flag. Define UART_RX_FIFO_FWFT_EN for first-word-fall-through
// read data; otherwise dout is registered and valid the cycle after rd_en.
module uart_rx_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_fifo_if.slave  bus
);

  localparam logic [ADDR_W:0] FullCount = (ADDR_W + 1)'(DEPTH);

  logic              rx_done_q, rx_done_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        mem_q [DEPTH];

  logic wr_strobe;
  logic is_empty;
  logic is_full;
  logic rd_acc;
  logic wr_acc;
  logic drop;

  // Accept decisions; a read on a full FIFO frees the slot the write needs
  always_comb begin
    is_empty  = (count_q == '0);
    is_full   = (count_q == FullCount);
    wr_strobe = bus.rx_done & ~rx_done_q;
    rd_acc    = bus.rd_en & ~is_empty;
    wr_acc    = wr_strobe & (~is_full | rd_acc);
    drop      = wr_strobe & is_full & ~rd_acc;
  end

  // Next-state for pointers, level, edge detector and overflow
  always_comb begin
    rx_done_d  = bus.rx_done;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end
    if (wr_acc && !rd_acc) begin
      count_d = count_q + (ADDR_W + 1)'(1);
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - (ADDR_W + 1)'(1);
    end
    // Set takes priority over clear
    if (bus.clear_ovf) begin
      overflow_d = 1'b0;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end
  end

  // Control state with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_done_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rx_done_q  <= rx_done_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents are not reset
  always_ff @(posedge clk) begin
    if (reset && wr_acc) begin
      mem_q[wr_ptr_q] <= bus.rx_data;
    end
  end

`ifdef UART_RX_FIFO_FWFT_EN
  // Head of queue shown directly; zero while nothing is stored
  always_comb begin
    bus.dout = is_empty ? 8'h00 : mem_q[rd_ptr_q];
  end
`else
  logic [7:0] dout_q, dout_d;

  // Registered read data, held between accepted reads
  always_comb begin
    dout_d = dout_q;
    if (rd_acc) begin
      dout_d = mem_q[rd_ptr_q];
    end
  end

  // Read data register
  always_ff @(posedge clk) begin
    if (!reset) begin
      dout_q <= 8'h00;
    end else begin
      dout_q <= dout_d;
    end
  end

  // Drive read data output
  always_comb begin
    bus.dout = dout_q;
  end
`endif

  // Status outputs, all from registered state
  always_comb begin
    bus.empty    = is_empty;
    bus.full     = is_full;
    bus.count    = count_q;
    bus.overflow = overflow_q;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (DEPTH=16). Inputs change 1ns after the
// rising edge; outputs are sampled at that same point, after the edge settles.
module tb_uart_rx_fifo;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  uart_rx_fifo_if #(.ADDR_W(4)) bus ();

  uart_rx_fifo #(
    .DEPTH (16),
    .ADDR_W(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle rx_done pulse followed by one low cycle
  task automatic pulse_byte(input logic [7:0] d);
    bus.rx_done = 1'b1;
    bus.rx_data = d;
    tick();
    bus.rx_done = 1'b0;
    tick();
  endtask

  // Pop one byte and compare it against exp
  task automatic read_byte(input string tag, input logic [7:0] exp);
`ifdef UART_RX_FIFO_FWFT_EN
    check_eq(tag, 32'(bus.dout), 32'(exp));
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
`else
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check_eq(tag, 32'(bus.dout), 32'(exp));
`endif
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    n_vec         = 0;
    n_err         = 0;
    reset         = 1'b0;
    bus.rx_done   = 1'b0;
    bus.rx_data   = 8'h00;
    bus.rd_en     = 1'b0;
    bus.clear_ovf = 1'b0;
    do_reset();

    // 1: reset state, three bytes in and out
    check_eq("rst_count", 32'(bus.count), 0);
    check_eq("rst_empty", 32'(bus.empty), 1);
    check_eq("rst_full", 32'(bus.full), 0);
    check_eq("rst_ovf", 32'(bus.overflow), 0);
    check_eq("rst_dout", 32'(bus.dout), 0);
    pulse_byte(8'h41);
    pulse_byte(8'h42);
    pulse_byte(8'h43);
    check_eq("t1_count3", 32'(bus.count), 3);
    check_eq("t1_empty0", 32'(bus.empty), 0);
    read_byte("t1_rd41", 8'h41);
    read_byte("t1_rd42", 8'h42);
    read_byte("t1_rd43", 8'h43);
    check_eq("t1_count0", 32'(bus.count), 0);
    check_eq("t1_empty1", 32'(bus.empty), 1);
    // rd_en while empty is ignored
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
`ifdef UART_RX_FIFO_FWFT_EN
    check_eq("t1_rdempty_dout", 32'(bus.dout), 32'h00);
`else
    check_eq("t1_rdempty_dout", 32'(bus.dout), 32'h43);
`endif
    check_eq("t1_rdempty_count", 32'(bus.count), 0);

    // 2: long rx_done is a single write
    bus.rx_done = 1'b1;
    bus.rx_data = 8'h55;
    repeat (20) tick();
    bus.rx_done = 1'b0;
    tick();
    check_eq("t2_count1", 32'(bus.count), 1);
    read_byte("t2_rd55", 8'h55);
    check_eq("t2_empty", 32'(bus.empty), 1);

    // 3: fill, overflow drop, drain, clear
    for (int i = 0; i < 16; i++) pulse_byte(8'(i));
    check_eq("t3_full", 32'(bus.full), 1);
    check_eq("t3_count16", 32'(bus.count), 16);
    check_eq("t3_ovf0", 32'(bus.overflow), 0);
    pulse_byte(8'hFF);
    check_eq("t3_ovf1", 32'(bus.overflow), 1);
    check_eq("t3_count_drop", 32'(bus.count), 16);
    for (int i = 0; i < 16; i++) read_byte("t3_drain", 8'(i));
    check_eq("t3_empty", 32'(bus.empty), 1);
    check_eq("t3_ovf_sticky", 32'(bus.overflow), 1);
    bus.clear_ovf = 1'b1;
    tick();
    bus.clear_ovf = 1'b0;
    check_eq("t3_ovf_clr", 32'(bus.overflow), 0);

    // 4: write and read together while full
    for (int i = 0; i < 16; i++) pulse_byte(8'(8'h10 + i));
    check_eq("t4_full", 32'(bus.full), 1);
`ifdef UART_RX_FIFO_FWFT_EN
    check_eq("t4_rd10", 32'(bus.dout), 32'h10);
`endif
    bus.rx_done = 1'b1;
    bus.rx_data = 8'hAA;
    bus.rd_en   = 1'b1;
    tick();
    bus.rx_done = 1'b0;
    bus.rd_en   = 1'b0;
`ifndef UART_RX_FIFO_FWFT_EN
    check_eq("t4_rd10", 32'(bus.dout), 32'h10);
`endif
    check_eq("t4_count16", 32'(bus.count), 16);
    check_eq("t4_ovf0", 32'(bus.overflow), 0);
    tick();
    for (int i = 1; i < 16; i++) read_byte("t4_drain", 8'(8'h10 + i));
    read_byte("t4_rdAA", 8'hAA);
    check_eq("t4_empty", 32'(bus.empty), 1);

    // 5: write/read pairs across pointer wrap
    for (int i = 0; i < 40; i++) begin
      pulse_byte(8'(8'h60 + i));
      check_eq("t5_count1", 32'(bus.count), 1);
      read_byte("t5_rd", 8'(8'h60 + i));
      check_eq("t5_count0", 32'(bus.count), 0);
    end

    // 6: reset with 5 stored bytes and overflow set
    for (int i = 0; i < 17; i++) pulse_byte(8'(8'hC0 + i));
    check_eq("t6_ovf1", 32'(bus.overflow), 1);
    for (int i = 0; i < 11; i++) read_byte("t6_pre", 8'(8'hC0 + i));
    check_eq("t6_count5", 32'(bus.count), 5);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_eq("t6_count0", 32'(bus.count), 0);
    check_eq("t6_empty", 32'(bus.empty), 1);
    check_eq("t6_ovf0", 32'(bus.overflow), 0);
    check_eq("t6_dout0", 32'(bus.dout), 0);
    pulse_byte(8'h37);
`ifdef UART_RX_FIFO_FWFT_EN
    check_eq("t6_fwft37", 32'(bus.dout), 32'h37);
`else
    check_eq("t6_hold0", 32'(bus.dout), 32'h00);
`endif
    read_byte("t6_rd37", 8'h37);
    check_eq("t6_empty_end", 32'(bus.empty), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
